fft8_seq: RTL and testbench
===========================

# fft8_seq

Frame sequencer for the 8-point FFT datapath (`fft8_fp`). It accepts complex samples one per cycle over a valid/ready stream and assembles eight of them into a frame. It drives the frame onto the FFT core's eight parallel input lanes, holds them stable for the core's latency, then captures the eight results. It streams the results back out serially with backpressure. The block sits between the sample source and the consumer, and owns all sequencing of the FFT core.

## Interface
Parameters:
- `DATA_W`, default 32: width of one complex sample (upper half real, lower half imaginary); passed through untouched.
- `FFT_LAT`, default 2: cycles from stable core inputs to valid core outputs; legal range 0..15.

Ports:
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `s_valid`, input, 1: input sample valid.
- `s_ready`, output, 1: block can accept a sample.
- `s_data`, input, DATA_W: input sample.
- `fft_in`, output, 8*DATA_W: core input lanes; lane k (the core's `in(k+1)`) occupies bits [k*DATA_W +: DATA_W].
- `fft_out`, input, 8*DATA_W: core output lanes, same packing.
- `m_valid`, output, 1: output sample valid.
- `m_ready`, input, 1: consumer accepts the output sample.
- `m_data`, output, DATA_W: output sample (bin `m_index`).
- `m_index`, output, 3: bin number of `m_data`.
- `m_last`, output, 1: high with bin 7.
- `busy`, output, 1: high in HOLD or DRAIN.
- `frame_cnt`, output, 16: completed frames; wraps from 0xFFFF to 0.

## Operation
- The state machine has three states: FILL, HOLD, DRAIN. Reset state is FILL.
- **FILL**
  - `s_ready`=1.
  - On each edge with `s_valid & s_ready`, lane `wr_idx` of the `fft_in` register is loaded with `s_data`, and `wr_idx` increments.
  - On the acceptance with `wr_idx`=7: `wr_idx` returns to 0, the hold counter is cleared, and the state goes to HOLD.
  - Lanes not yet rewritten keep the previous frame's values.
- **HOLD**
  - `s_ready`=0 and `fft_in` is frozen.
  - The hold counter counts 0..FFT_LAT.
  - On the edge where the counter equals FFT_LAT, all eight `fft_out` lanes are captured into the output buffer, `rd_idx` is set to 0, and the state goes to DRAIN.
- **DRAIN**
  - `m_valid`=1, `m_data`=obuf[`rd_idx`], `m_index`=`rd_idx`, `m_last`=(`rd_idx`==7).
  - On `m_valid & m_ready`, `rd_idx` increments.
  - On the handshake with `rd_idx`=7:
    - state goes to FILL;
    - `frame_cnt` increments;
    - `rd_idx` returns to 0.
  - `s_ready`=0 throughout DRAIN; there is no overlap of fill and drain.
- Data is never modified. The block performs no arithmetic on samples; the only counters are `wr_idx`/`rd_idx` (3 bits, wrapping), the hold counter (4 bits) and `frame_cnt`.
- `m_data`, `m_index` and `m_last` are stable while `m_valid & !m_ready`.
- `s_valid` while `s_ready`=0 is ignored; the source must hold the sample.

## Timing
- Reset values:
  - `s_ready`=1 (state FILL); samples presented while `rst_n`=0 are not captured.
  - `m_valid`=0, `m_data`=0, `m_index`=0, `m_last`=0.
  - `busy`=0, `frame_cnt`=0, `fft_in`=0, output buffer 0, all indices 0.
- Reset asserted mid-frame (in FILL, HOLD or DRAIN) aborts immediately; after release the block is in FILL, expecting sample 0 of a new frame.
- Throughput in FILL: one sample per cycle.
- Latency: the edge accepting sample 7 moves the block to HOLD. HOLD lasts FFT_LAT+1 cycles. `m_valid` rises FFT_LAT+1 cycles after that edge.
- With `m_ready` held high, DRAIN lasts exactly 8 cycles, and `s_ready` rises the cycle after the bin-7 handshake. The minimum frame period is therefore 8 + (FFT_LAT+1) + 8 cycles.
- `s_ready`, `m_valid`, `m_last` and `busy` are decoded from registered state only, with no combinational path from `s_valid` or `m_ready`.
- FFT_LAT=0: HOLD lasts one cycle and captures `fft_out` on the edge after the frame completes.

## Test plan
1. **Reset defaults.**
   - Stimulus: hold `rst_n`=0, then release.
   - Required response: `s_ready`=1, `m_valid`=0, `fft_in`=0, `frame_cnt`=0, `busy`=0.
2. **Single frame.**
   - Stimulus: FFT_LAT=2; bench core model returns each lane XOR 0xA5A5A5A5 after 2 cycles. Stream 3c000000, 40000000, 42000000, 44000000, 44000000, 42000000, 40000000, 3c000000 back-to-back with `m_ready`=1.
   - Required response:
     - `fft_in` lanes match the streamed values in order;
     - `m_valid` rises 3 cycles after the 8th accept;
     - bins 0..7 are 99a5a5a5, e5a5a5a5, e7a5a5a5, e1a5a5a5, e1a5a5a5, e7a5a5a5, e5a5a5a5, 99a5a5a5;
     - `m_last` is high only on bin 7;
     - `frame_cnt`=1.
3. **Input gaps and ignored input.**
   - Stimulus: `s_valid` toggling 1,0,1,0 during FILL; `s_valid`=1 held during HOLD and DRAIN.
   - Required response: frame assembled from valid beats only; no capture while `s_ready`=0; `fft_in` unchanged during HOLD.
4. **Output backpressure.**
   - Stimulus: `m_ready`=0 for 5 cycles at bin 3.
   - Required response: `m_data`, `m_index`=3 and `m_valid` held stable; bin 4 follows the release; `s_ready` stays 0 until the bin-7 handshake.
5. **Mid-frame reset.**
   - Stimulus: assert `rst_n`=0 after 5 samples, and separately during DRAIN at bin 2.
   - Required response: all outputs return to reset values; the next 8 accepted samples form a complete fresh frame.
6. **Counter wrap and back-to-back frames.**
   - Stimulus: preload via 65536 frames (or force `frame_cnt`=0xFFFF).
   - Required response: `frame_cnt` wraps to 0; consecutive frames keep the 8 + (FFT_LAT+1) + 8 cycle period.

Source files
------------

// File: rtl/fft8_seq.sv
// fft8_seq: gathers eight streamed samples into a frame, holds it on the FFT
// core lanes for FFT_LAT+1 cycles, captures the results and streams them out.
module fft8_seq #(
  parameter int DATA_W  = 32,
  parameter int FFT_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_W-1:0]     s_data,
  output logic [8*DATA_W-1:0]   fft_in,
  input  logic [8*DATA_W-1:0]   fft_out,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_W-1:0]     m_data,
  output logic [2:0]            m_index,
  output logic                  m_last,
  output logic                  busy,
  output logic [15:0]           frame_cnt
);
  typedef enum logic [1:0] {FILL, HOLD, DRAIN} state_t;
  localparam logic [3:0] LAT = 4'(FFT_LAT);
  state_t state;
  logic [2:0] wr_idx, rd_idx;
  logic [3:0] hcnt;
  logic [7:0][DATA_W-1:0] lanes, obuf;
  // handshake flags come only from the state register, never from s_valid/m_ready
  assign s_ready = state == FILL;
  assign m_valid = state == DRAIN;
  assign busy    = state != FILL;
  assign m_last  = m_valid && rd_idx == 3'd7;
  assign m_index = rd_idx;
  assign m_data  = obuf[rd_idx];
  assign fft_in  = lanes;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      wr_idx    <= '0;
      rd_idx    <= '0;
      hcnt      <= '0;
      lanes     <= '0;
      obuf      <= '0;
      frame_cnt <= '0;
    end else begin
      case (state)
        FILL: if (s_valid) begin
          lanes[wr_idx] <= s_data;
          wr_idx        <= wr_idx + 3'd1;
          if (wr_idx == 3'd7) begin
            hcnt  <= '0;
            state <= HOLD;
          end
        end
        HOLD: begin
          hcnt <= hcnt + 4'd1;
          if (hcnt == LAT) begin
            obuf   <= fft_out;
            rd_idx <= '0;
            state  <= DRAIN;
          end
        end
        DRAIN: if (m_ready) begin
          rd_idx <= rd_idx + 3'd1;
          if (rd_idx == 3'd7) begin
            frame_cnt <= frame_cnt + 16'd1;
            state     <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_fft8_seq.sv
// tb_fft8_seq: table vectors plus scoreboard checking of the fft8_seq frame sequencer.
module tb_fft8_seq;
  localparam logic [31:0] MASK = 32'ha5a5a5a5;
  logic clk = 0, rst_n = 0, s_valid = 0, m_ready = 1;
  logic [31:0] s_data = '0;
  logic s_ready, m_valid, m_last, busy;
  logic [31:0] m_data;
  logic [2:0] m_index;
  logic [15:0] frame_cnt;
  logic [255:0] fft_in, fft_out, p1, p2;
  typedef struct {logic [31:0] d; logic [2:0] i; logic l;} exp_t;
  typedef struct {logic [31:0] in; logic [31:0] exp;} vec_t;
  exp_t q[$];
  exp_t mon_e;
  vec_t tv[8];
  logic [31:0] din[8], dexp[8];
  int n_cmp = 0, n_err = 0, cyc = 0, acc_t = 0, fc = 0;
  int t0[3];

  fft8_seq dut (.clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .fft_in(fft_in), .fft_out(fft_out), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_index(m_index), .m_last(m_last), .busy(busy), .frame_cnt(frame_cnt));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // core model: every lane XOR MASK, two-cycle pipeline
  always @(posedge clk) begin
    p1 <= fft_in ^ {8{MASK}};
    p2 <= p1;
  end
  assign fft_out = p2;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) if (rst_n && m_valid && m_ready) begin
    if (q.size() == 0) chk("unexpected_output", {61'd0, m_index}, 64'hffff);
    else begin
      mon_e = q.pop_front();
      chk("bin_data", m_data, mon_e.d);
      chk("bin_index", m_index, mon_e.i);
      chk("bin_last", m_last, mon_e.l);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sample(input logic [31:0] d);
    int t = 0;
    s_valid = 1;
    s_data = d;
    @(negedge clk);
    while (!s_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("s_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    acc_t = cyc;
    s_valid = 0;
  endtask

  task automatic new_frame();
    for (int k = 0; k < 8; k++) begin
      din[k] = $urandom;
      dexp[k] = din[k] ^ MASK;
    end
  endtask

  task automatic push_expected();
    for (int k = 0; k < 8; k++) q.push_back('{dexp[k], 3'(k), k == 7});
  endtask

  task automatic wait_fill(input string nm);
    int c = 0;
    while (!s_ready && c < 60) begin
      if (m_valid && m_last && m_ready) s_valid = 0;
      tick();
      c++;
    end
    if (c >= 60) chk(nm, 0, 1);
  endtask

  task automatic run_frame(input bit gaps, input bit junk);
    int c = 0;
    logic [255:0] exp_lanes;
    for (int i = 0; i < 8; i++) begin
      push_sample(din[i]);
      if (gaps && i < 7) tick();
    end
    push_expected();
    for (int k = 0; k < 8; k++) begin
      chk("fft_in_lane", fft_in[k*32 +: 32], din[k]);
      exp_lanes[k*32 +: 32] = din[k];
    end
    if (junk) begin
      s_valid = 1;
      s_data = 32'hdeadbeef;
    end
    while (!m_valid && c < 20) begin
      chk("hold_s_ready", s_ready, 0);
      chk("hold_busy", busy, 1);
      if (junk) chk("hold_fft_in_frozen", fft_in == exp_lanes, 1);
      tick();
      c++;
    end
    chk("latency", c, 3);
    wait_fill("drain_timeout");
    if (junk) chk("junk_not_captured", fft_in == exp_lanes, 1);
    fc++;
    chk("frame_cnt", frame_cnt, fc);
  endtask

  initial begin
    tv[0] = '{32'h3c000000, 32'h99a5a5a5}; tv[1] = '{32'h40000000, 32'he5a5a5a5};
    tv[2] = '{32'h42000000, 32'he7a5a5a5}; tv[3] = '{32'h44000000, 32'he1a5a5a5};
    tv[4] = '{32'h44000000, 32'he1a5a5a5}; tv[5] = '{32'h42000000, 32'he7a5a5a5};
    tv[6] = '{32'h40000000, 32'he5a5a5a5}; tv[7] = '{32'h3c000000, 32'h99a5a5a5};
    // reset with a sample presented: must not be captured
    s_valid = 1;
    s_data = 32'h12345678;
    repeat (3) tick();
    s_valid = 0;
    rst_n = 1;
    tick();
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_fft_in", fft_in == '0, 1);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_index", m_index, 0);
    chk("rst_m_last", m_last, 0);

    // single frame from the table
    for (int k = 0; k < 8; k++) begin
      din[k] = tv[k].in;
      dexp[k] = tv[k].exp;
    end
    run_frame(0, 0);

    // gapped input with s_valid held through HOLD and DRAIN
    new_frame();
    run_frame(1, 1);

    // backpressure at bin 3
    new_frame();
    for (int i = 0; i < 8; i++) push_sample(din[i]);
    push_expected();
    begin
      int c = 0;
      while (!(m_valid && m_index == 3) && c < 30) begin tick(); c++; end
      chk("reach_bin3", c < 30, 1);
    end
    m_ready = 0;
    repeat (5) begin
      tick();
      chk("bp_m_valid", m_valid, 1);
      chk("bp_m_index", m_index, 3);
      chk("bp_m_data", m_data, dexp[3]);
      chk("bp_s_ready", s_ready, 0);
    end
    m_ready = 1;
    tick();
    chk("bp_next_bin", m_index, 4);
    chk("bp_s_ready_after", s_ready, 0);
    wait_fill("bp_drain_timeout");
    fc++;
    chk("bp_frame_cnt", frame_cnt, fc);

    // reset after five samples
    new_frame();
    for (int i = 0; i < 5; i++) push_sample(din[i]);
    rst_n = 0;
    #1;
    chk("mrst_s_ready", s_ready, 1);
    chk("mrst_busy", busy, 0);
    chk("mrst_fft_in", fft_in == '0, 1);
    chk("mrst_frame_cnt", frame_cnt, 0);
    fc = 0;
    tick();
    rst_n = 1;
    tick();
    new_frame();
    run_frame(0, 0);

    // reset during DRAIN at bin 2
    new_frame();
    for (int i = 0; i < 8; i++) push_sample(din[i]);
    push_expected();
    begin
      int c = 0;
      while (!(m_valid && m_index == 2) && c < 30) begin tick(); c++; end
      chk("reach_bin2", c < 30, 1);
    end
    rst_n = 0;
    #1;
    q.delete();
    chk("drst_m_valid", m_valid, 0);
    chk("drst_m_data", m_data, 0);
    chk("drst_m_index", m_index, 0);
    chk("drst_m_last", m_last, 0);
    chk("drst_s_ready", s_ready, 1);
    chk("drst_frame_cnt", frame_cnt, 0);
    fc = 0;
    tick();
    rst_n = 1;
    tick();
    new_frame();
    run_frame(0, 0);

    // counter wrap with back-to-back frames
    force dut.frame_cnt = 16'hfffd;
    #1;
    release dut.frame_cnt;
    for (int f = 0; f < 3; f++) begin
      new_frame();
      for (int i = 0; i < 8; i++) begin
        push_sample(din[i]);
        if (i == 0) t0[f] = acc_t;
      end
      push_expected();
    end
    wait_fill("b2b_drain_timeout");
    chk("period_0", t0[1] - t0[0], 19);
    chk("period_1", t0[2] - t0[1], 19);
    chk("wrap_frame_cnt", frame_cnt, 0);
    chk("queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
